ddr_native_arbiter: RTL and testbench

- Round-robin arbiter sharing the single DDR native-bus port (toward the cache/AXI bridge feeding the DDR controller) between N_MASTERS native-bus requesters, e.g. CPU data path and ethernet DMA.
- Captures the winning request into registers and holds it stable on the slave side until the slave completes it.
- Returns completion and read data to the granted requester only.
- Tracks stalled transactions with a sticky timeout flag.

---
 rtl/ddr_native_arbiter_pkg.sv | 19 +
 rtl/ddr_native_arbiter_if.sv | 40 ++++
 rtl/rr_priority_sel.sv | 30 +++
 rtl/ddr_native_arbiter.sv | 123 ++++++++++++
 tb/tb_ddr_native_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ddr_native_arbiter_pkg.sv
// Shared FSM encoding, width helper and packed-vector slicing macro for the
// DDR native-bus arbiter and related schedulers.
`ifndef DDR_NB_FIELD
`define DDR_NB_FIELD(vec, idx, w) vec[(idx)*(w) +: (w)]
`endif

package ddr_native_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Index width that never collapses to zero bits for a single requester.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ddr_native_arbiter_if.sv
// Native-bus bundle between the requesters, the arbiter and the DDR port.
// The arbiter takes the master modport (it masters the DDR port).
interface ddr_native_arbiter_if
    import ddr_native_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned GRANT_W = clog2_min1(N_MASTERS);

    logic [N_MASTERS-1:0]        m_valid;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS*STRB_W-1:0] m_wstrb;
    logic [DATA_W-1:0]           m_rdata;
    logic [N_MASTERS-1:0]        m_ready;
    logic                        s_valid;
    logic [ADDR_W-1:0]           s_addr;
    logic [DATA_W-1:0]           s_wdata;
    logic [STRB_W-1:0]           s_wstrb;
    logic [DATA_W-1:0]           s_rdata;
    logic                        s_ready;
    logic [GRANT_W-1:0]          grant;
    logic                        busy;
    logic                        timeout;
    logic                        timeout_clr;

    modport master (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready, timeout_clr,
        output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, grant, busy, timeout
    );

    modport slave (
        output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready, timeout_clr,
        input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb, grant, busy, timeout
    );

endinterface

// File: rtl/rr_priority_sel.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping modulo N_REQ (works for non-power-of-two N_REQ).
module rr_priority_sel #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        w_found = 1'b0;
        w_pos   = '0;
        o_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            w_pos = IDX_W'((int'(i_ptr) + i) % int'(N_REQ));
            if (!w_found && i_req[w_pos]) begin
                w_found = 1'b1;
                o_idx   = w_pos;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/ddr_native_arbiter.sv
// Round-robin arbiter sharing one DDR native-bus port between N_MASTERS
// requesters; holds the captured request until the slave completes it.
module ddr_native_arbiter
    import ddr_native_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                resetn,
    ddr_native_arbiter_if.master io_bus
);

    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned GRANT_W = clog2_min1(N_MASTERS);
    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_ARM  = CNT_W'(TIMEOUT - 2);
    localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(N_MASTERS - 1);

    arb_state_e         r_state, w_state_nxt;
    logic [GRANT_W-1:0] r_ptr, w_ptr_nxt;
    logic [GRANT_W-1:0] r_grant, w_grant_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt;
    logic [STRB_W-1:0]  r_wstrb, w_wstrb_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_timeout, w_timeout_nxt;
    logic [GRANT_W-1:0] w_win;
    logic               w_any;
    logic               w_to_set;
    logic [N_MASTERS-1:0] w_m_ready;

    rr_priority_sel #(
        .N_REQ (N_MASTERS),
        .IDX_W (GRANT_W)
    ) u_sel (
        .i_req (io_bus.m_valid),
        .i_ptr (r_ptr),
        .o_idx (w_win),
        .o_any (w_any)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_cnt_nxt     = r_cnt;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ARB_BUSY;
                    w_grant_nxt = w_win;
                    w_addr_nxt  = `DDR_NB_FIELD(io_bus.m_addr, w_win, ADDR_W);
                    w_wdata_nxt = `DDR_NB_FIELD(io_bus.m_wdata, w_win, DATA_W);
                    w_wstrb_nxt = `DDR_NB_FIELD(io_bus.m_wstrb, w_win, STRB_W);
                    w_cnt_nxt   = '0;
                end
            end
            ARB_BUSY: begin
                if (io_bus.s_ready) begin
                    w_state_nxt = ARB_IDLE;
                    w_ptr_nxt   = (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase

        // Set fires only on the transition into saturation, so a clear sticks
        // even while the same transaction keeps stalling.
        w_to_set      = (r_state == ARB_BUSY) && !io_bus.s_ready && (r_cnt == CNT_ARM);
        w_timeout_nxt = r_timeout;
        if (w_to_set) begin
            w_timeout_nxt = 1'b1;
        end else if (io_bus.timeout_clr) begin
            w_timeout_nxt = 1'b0;
        end

        for (int i = 0; i < int'(N_MASTERS); i++) begin
            w_m_ready[i] = (r_state == ARB_BUSY) && io_bus.s_ready && (r_grant == GRANT_W'(i));
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ARB_IDLE;
            r_ptr     <= '0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_grant   <= w_grant_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign io_bus.s_valid = (r_state == ARB_BUSY);
    assign io_bus.busy    = (r_state == ARB_BUSY);
    assign io_bus.s_addr  = r_addr;
    assign io_bus.s_wdata = r_wdata;
    assign io_bus.s_wstrb = r_wstrb;
    assign io_bus.grant   = r_grant;
    assign io_bus.timeout = r_timeout;
    assign io_bus.m_ready = w_m_ready;
    assign io_bus.m_rdata = io_bus.s_rdata;

endmodule

// File: tb/tb_ddr_native_arbiter.sv
// Directed bench for ddr_native_arbiter: two masters, TIMEOUT=8.
module tb_ddr_native_arbiter;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_errors;

    ddr_native_arbiter_if #(
        .N_MASTERS (2),
        .ADDR_W    (32),
        .DATA_W    (32)
    ) bus ();

    ddr_native_arbiter #(
        .N_MASTERS (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .TIMEOUT   (8)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.m_valid     = '0;
        bus.m_addr      = '0;
        bus.m_wdata     = '0;
        bus.m_wstrb     = '0;
        bus.s_rdata     = '0;
        bus.s_ready     = 1'b0;
        bus.timeout_clr = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        clear_inputs();
        #3;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        clear_inputs();
        #12;
        check_eq("rst_s_valid", 64'(bus.s_valid), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_timeout", 64'(bus.timeout), 64'd0);
        check_eq("rst_grant", 64'(bus.grant), 64'd0);
        check_eq("rst_m_ready", 64'(bus.m_ready), 64'd0);
        check_eq("rst_s_addr", 64'(bus.s_addr), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single read from master0, slave answers in the 4th BUSY cycle.
        bus.m_valid          = 2'b01;
        bus.m_addr[0 +: 32]  = 32'h0000_0100;
        #1;
        check_eq("rd_c0_s_valid", 64'(bus.s_valid), 64'd0);
        tick();
        check_eq("rd_c1_s_valid", 64'(bus.s_valid), 64'd1);
        check_eq("rd_c1_s_addr", 64'(bus.s_addr), 64'h100);
        check_eq("rd_c1_grant", 64'(bus.grant), 64'd0);
        check_eq("rd_c1_m_ready", 64'(bus.m_ready), 64'd0);
        tick();
        tick();
        check_eq("rd_c3_m_ready", 64'(bus.m_ready), 64'd0);
        tick();
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_c4_m_ready", 64'(bus.m_ready), 64'b01);
        check_eq("rd_c4_m_rdata", 64'(bus.m_rdata), 64'hDEAD_BEEF);
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;
        check_eq("rd_c5_s_valid", 64'(bus.s_valid), 64'd0);
        check_eq("rd_c5_busy", 64'(bus.busy), 64'd0);

        // Simultaneous writes from a fresh pointer; slave always ready.
        apply_reset();
        bus.m_valid          = 2'b11;
        bus.m_wdata[0 +: 32] = 32'hA;
        bus.m_wdata[32 +: 32] = 32'hB;
        bus.m_wstrb          = 8'hFF;
        bus.s_ready          = 1'b1;
        tick();
        check_eq("sim_t1_grant", 64'(bus.grant), 64'd0);
        check_eq("sim_t1_s_wdata", 64'(bus.s_wdata), 64'hA);
        check_eq("sim_t1_m_ready", 64'(bus.m_ready), 64'b01);
        tick();
        bus.m_valid = 2'b10;
        check_eq("sim_idle_s_valid", 64'(bus.s_valid), 64'd0);
        check_eq("sim_idle_m_ready", 64'(bus.m_ready), 64'd0);
        tick();
        check_eq("sim_t2_grant", 64'(bus.grant), 64'd1);
        check_eq("sim_t2_s_wdata", 64'(bus.s_wdata), 64'hB);
        check_eq("sim_t2_m_ready", 64'(bus.m_ready), 64'b10);
        tick();
        bus.m_valid = 2'b00;
        check_eq("sim_end_busy", 64'(bus.busy), 64'd0);

        // Fairness: both keep requesting; pointer is back at 0.
        bus.m_valid = 2'b11;
        for (int t = 0; t < 6; t++) begin
            tick();
            check_eq($sformatf("fair_%0d_grant", t), 64'(bus.grant), 64'(t % 2));
            check_eq($sformatf("fair_%0d_m_ready", t), 64'(bus.m_ready),
                     64'((t % 2) ? 2'b10 : 2'b01));
            tick();
            check_eq($sformatf("fair_%0d_idle", t), 64'(bus.s_valid), 64'd0);
        end
        bus.m_valid = 2'b00;
        bus.s_ready = 1'b0;

        // Byte write from master1; captured fields hold while inputs change.
        bus.m_valid           = 2'b10;
        bus.m_addr[32 +: 32]  = 32'h0000_0440;
        bus.m_wdata[32 +: 32] = 32'h0055_0000;
        bus.m_wstrb           = 8'h40;
        tick();
        bus.m_wstrb           = 8'hF0;
        bus.m_wdata[32 +: 32] = 32'h0;
        check_eq("bw_grant", 64'(bus.grant), 64'd1);
        check_eq("bw_s_wstrb", 64'(bus.s_wstrb), 64'h4);
        check_eq("bw_s_wdata", 64'(bus.s_wdata), 64'h0055_0000);
        tick();
        tick();
        check_eq("bw_hold_s_wstrb", 64'(bus.s_wstrb), 64'h4);
        check_eq("bw_hold_s_wdata", 64'(bus.s_wdata), 64'h0055_0000);
        check_eq("bw_hold_m_ready", 64'(bus.m_ready), 64'd0);
        bus.s_ready = 1'b1;
        #1;
        check_eq("bw_m_ready", 64'(bus.m_ready), 64'b10);
        tick();
        bus.s_ready = 1'b0;
        bus.m_valid = 2'b00;
        bus.m_wstrb = '0;

        // Timeout: stall, master drops valid after grant, then clear and finish.
        bus.m_valid          = 2'b01;
        bus.m_addr[0 +: 32]  = 32'h0000_0200;
        tick();
        bus.m_valid = 2'b00;
        for (int c = 2; c <= 11; c++) begin
            tick();
            if (c == 6) check_eq("to_c6_timeout", 64'(bus.timeout), 64'd0);
            if (c == 9) check_eq("to_c9_timeout", 64'(bus.timeout), 64'd1);
        end
        check_eq("to_c11_timeout", 64'(bus.timeout), 64'd1);
        check_eq("to_c11_busy", 64'(bus.busy), 64'd1);
        bus.timeout_clr = 1'b1;
        tick();
        bus.timeout_clr = 1'b0;
        check_eq("to_clr_timeout", 64'(bus.timeout), 64'd0);
        tick();
        check_eq("to_after_clr", 64'(bus.timeout), 64'd0);
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h1234_5678;
        #1;
        check_eq("to_m_ready", 64'(bus.m_ready), 64'b01);
        check_eq("to_m_rdata", 64'(bus.m_rdata), 64'h1234_5678);
        tick();
        bus.s_ready = 1'b0;
        check_eq("to_done_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset while BUSY.
        bus.m_valid = 2'b01;
        tick();
        check_eq("ar_busy", 64'(bus.busy), 64'd1);
        bus.s_ready = 1'b1;
        #1;
        check_eq("ar_m_ready_pre", 64'(bus.m_ready), 64'b01);
        #1;
        resetn = 1'b0;
        #1;
        check_eq("ar_s_valid", 64'(bus.s_valid), 64'd0);
        check_eq("ar_busy_low", 64'(bus.busy), 64'd0);
        check_eq("ar_m_ready", 64'(bus.m_ready), 64'd0);
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        bus.m_valid = 2'b10;
        tick();
        check_eq("ar_new_grant", 64'(bus.grant), 64'd1);
        check_eq("ar_new_s_valid", 64'(bus.s_valid), 64'd1);
        bus.s_ready = 1'b1;
        #1;
        check_eq("ar_new_m_ready", 64'(bus.m_ready), 64'b10);
        tick();
        clear_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
